// File: rtl/adv7393_frame_fetch_pkg.sv
// Shared types and constants for the ADV7393 frame-buffer fetch engine.
package adv7393_frame_fetch_pkg;

  localparam int unsigned MAX_BURST        = 16;
  localparam int unsigned FIFO_DEPTH       = 64;
  localparam int unsigned PIXELS_IN_SYMBOL = 4;
  localparam logic [2:0]  AXI_SIZE_16B     = 3'b100;

  typedef enum logic [1:0] {IDLE, ARM, REQ, DATA} FetchState_t;

  typedef struct packed {
    logic [15:0] LineLength;
    logic [15:0] Lines;
    logic [7:0]  FramePhases;
  } FrameCtrl_t;

  typedef struct packed {
    logic [31:0] Base;
    logic [31:0] LineStep;
    logic [7:0]  Count;
  } BufferCtrl_t;

endpackage

// File: rtl/adv7393_frame_fetch_sym.sv
// Symbol FIFO: synchronous, flop-based, zero output when empty, exposes free count.
module adv7393_sym_fifo #(
  parameter int unsigned WIDTH = 130,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      free
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A read in the same cycle frees the slot, so a full FIFO still accepts a write.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && ((count != FULL) || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign free     = FULL - count;

endmodule

// File: rtl/adv7393_frame_fetch.sv
// Frame-buffer read engine: per field_start, fetches one phase's lines in AXI bursts
// and streams them out as 128-bit symbols through the symbol FIFO.
import adv7393_frame_fetch_pkg::*;

module adv7393_frame_fetch #(
  parameter int unsigned M_AXI_DWIDTH = 128,
  parameter int unsigned MAX_BURST    = adv7393_frame_fetch_pkg::MAX_BURST,
  parameter int unsigned FIFO_DEPTH   = adv7393_frame_fetch_pkg::FIFO_DEPTH
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  FrameCtrl_t              frame,
  input  BufferCtrl_t             buffer,
  input  logic                    field_start,
  output logic [31:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [M_AXI_DWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [M_AXI_DWIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic [7:0]              phase,
  output logic [7:0]              buf_idx,
  output logic                    busy,
  output logic                    err_resp,
  output logic                    err_ovr,
  output logic                    err_cfg
);

  localparam int unsigned FAW     = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0] CREDIT = (FAW+1)'(MAX_BURST);
  localparam logic [15:0] BURST16 = 16'(MAX_BURST);

  FetchState_t state;
  FrameCtrl_t  frame_q;
  BufferCtrl_t buffer_q;
  logic [1:0]  pre_cnt;
  logic [31:0] stride, lstep, line_addr;
  logic [15:0] sym, sent, sent_nxt, rem, burst_len;
  logic [16:0] line, line_nxt;
  logic [7:0]  phase_nxt, buf_nxt;
  logic        first_sym, beat, cfg_bad, phase_wrap;
  logic [FAW:0] fifo_free;

  assign m_axi_rready = (state == DATA);
  assign beat         = m_axi_rvalid && m_axi_rready;
  assign sent_nxt     = sent + 16'd1;
  assign rem          = sym - sent;
  assign burst_len    = (rem > BURST16) ? BURST16 : rem;
  assign line_nxt     = line + 17'(frame_q.FramePhases);
  assign phase_nxt    = phase + 8'd1;
  assign phase_wrap   = (phase_nxt >= frame_q.FramePhases);
  assign buf_nxt      = !phase_wrap ? buf_idx :
                        ((buf_idx + 8'd1 >= buffer_q.Count) ? '0 : buf_idx + 8'd1);
  assign cfg_bad      = (frame.LineLength == '0) || (frame.Lines == '0) ||
                        (frame.FramePhases == '0) || (buffer.Count == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      frame_q       <= '0;
      buffer_q      <= '0;
      pre_cnt       <= '0;
      stride        <= '0;
      lstep         <= '0;
      sym           <= '0;
      line_addr     <= '0;
      line          <= '0;
      sent          <= '0;
      first_sym     <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      phase         <= '0;
      buf_idx       <= '0;
      busy          <= 1'b0;
      err_resp      <= 1'b0;
      err_ovr       <= 1'b0;
      err_cfg       <= 1'b0;
    end else begin
      if (field_start && busy) err_ovr <= 1'b1;
      if (beat && (m_axi_rresp != 2'b00)) err_resp <= 1'b1;

      case (state)
        IDLE: begin
          pre_cnt <= '0;
          if (enable) state <= ARM;
        end

        ARM: begin
          if (!enable) begin
            state   <= IDLE;
            pre_cnt <= '0;
            phase   <= '0;
            buf_idx <= '0;
          end else if (pre_cnt == 2'd0) begin
            if (field_start) begin
              if (phase != '0) begin
                pre_cnt <= 2'd1;
              end else if (cfg_bad) begin
                err_cfg <= 1'b1;
              end else begin
                frame_q           <= frame;
                buffer_q.Base     <= {buffer.Base[31:4], 4'h0};
                buffer_q.LineStep <= {buffer.LineStep[31:4], 4'h0};
                buffer_q.Count    <= buffer.Count;
                pre_cnt           <= 2'd1;
              end
            end
          end else if (pre_cnt == 2'd1) begin
            stride  <= 32'(frame_q.Lines) * buffer_q.LineStep;
            lstep   <= 32'(frame_q.FramePhases) * buffer_q.LineStep;
            sym     <= 16'((17'(frame_q.LineLength) + 17'(PIXELS_IN_SYMBOL - 1)) /
                           17'(PIXELS_IN_SYMBOL));
            pre_cnt <= 2'd2;
          end else begin
            line_addr <= buffer_q.Base + 32'(buf_idx) * stride +
                         32'(phase) * buffer_q.LineStep;
            line      <= 17'(phase);
            sent      <= '0;
            first_sym <= 1'b1;
            pre_cnt   <= '0;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!m_axi_arvalid) begin
            if (!enable) begin
              state   <= IDLE;
              busy    <= 1'b0;
              phase   <= '0;
              buf_idx <= '0;
            end else if (fifo_free >= CREDIT) begin
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= line_addr + {12'h000, sent, 4'h0};
              m_axi_arlen   <= 8'(burst_len - 16'd1);
            end
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= DATA;
          end
        end

        DATA: begin
          if (beat) begin
            sent      <= sent_nxt;
            first_sym <= 1'b0;
            if (m_axi_rlast) begin
              if (sent_nxt >= sym) begin
                sent      <= '0;
                line      <= line_nxt;
                line_addr <= line_addr + lstep;
              end
              // Disable wins once the burst is closed; otherwise continue line/phase.
              if (!enable) begin
                state   <= IDLE;
                busy    <= 1'b0;
                phase   <= '0;
                buf_idx <= '0;
              end else if ((sent_nxt < sym) || (line_nxt < {1'b0, frame_q.Lines})) begin
                state <= REQ;
              end else begin
                state   <= ARM;
                busy    <= 1'b0;
                phase   <= phase_wrap ? '0 : phase_nxt;
                buf_idx <= buf_nxt;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  adv7393_sym_fifo #(
    .WIDTH(M_AXI_DWIDTH + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (beat),
    .wr_data ({m_axi_rdata, (sent_nxt == sym), first_sym}),
    .rd_en   (m_tready),
    .rd_data ({m_tdata, m_tlast, m_tuser}),
    .rd_valid(m_tvalid),
    .free    (fifo_free)
  );

endmodule

// File: tb/tb_adv7393_frame_fetch.sv
// Self-checking bench for adv7393_frame_fetch: random-timing AXI slave and sink,
// expectations from a line/burst model of the frame layout.
module tb_adv7393_frame_fetch;
  import adv7393_frame_fetch_pkg::*;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [127:0] d; logic last; logic user; } sym_t;

  logic aclk = 1'b0;
  logic aresetn, enable, field_start;
  FrameCtrl_t  frame;
  BufferCtrl_t buffer;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arvalid, m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [127:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [7:0]  phase, buf_idx;
  logic        busy, err_resp, err_ovr, err_cfg;

  int tests = 0;
  int fails = 0;
  bit bp = 1'b0;
  bit inject_err = 1'b0;
  int cfg_ll, cfg_nl, cfg_fp, cfg_cnt;
  logic [31:0] cfg_base, cfg_step;
  int m_phase, m_buf;
  ar_t  ar_log[$], exp_ar[$];
  sym_t rx[$], exp_sym[$];

  always #5 aclk = ~aclk;

  adv7393_frame_fetch #(.M_AXI_DWIDTH(128), .MAX_BURST(16), .FIFO_DEPTH(64)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .frame(frame), .buffer(buffer),
    .field_start(field_start),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .phase(phase), .buf_idx(buf_idx),
    .busy(busy), .err_resp(err_resp), .err_ovr(err_ovr), .err_cfg(err_cfg)
  );

  function automatic logic [127:0] mkdata(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 ^ {a[15:0], a[31:16]}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: random AR acceptance delay and random R gaps; data is a function of address.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    int n;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axi_arvalid && ($urandom_range(0, 2) != 0)) begin
        a = m_axi_araddr; l = m_axi_arlen;
        ar_log.push_back('{addr: a, len: l});
        m_axi_arready = 1'b1;
        @(negedge aclk);
        m_axi_arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          while (aresetn && ($urandom_range(0, 3) == 0)) @(negedge aclk);
          if (!aresetn) break;
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mkdata(a + 32'(b * 16));
          m_axi_rlast  = (b == int'(l));
          m_axi_rresp  = inject_err ? 2'b10 : 2'b00;
          inject_err   = 1'b0;
          n = 0;
          while (!m_axi_rready && aresetn && n < 200) begin @(negedge aclk); n++; end
          @(negedge aclk);
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end
    end
  end

  // Symbol sink with random backpressure, or full stall while bp is set.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(negedge aclk);
      m_tready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (m_tvalid && m_tready) rx.push_back('{d: m_tdata, last: m_tlast, user: m_tuser});
    end
  end

  // Expected bursts and symbols of one phase, derived directly from the frame layout.
  task automatic model_phase(input int p, input int b);
    logic [31:0] base_m, step_m, la;
    int sym;
    base_m = cfg_base & 32'hFFFF_FFF0;
    step_m = cfg_step & 32'hFFFF_FFF0;
    sym = (cfg_ll + 3) / 4;
    for (int ln = p; ln < cfg_nl; ln += cfg_fp) begin
      la = base_m + 32'(b) * 32'(cfg_nl) * step_m + 32'(ln) * step_m;
      for (int off = 0; off < sym; off += 16)
        exp_ar.push_back('{addr: la + 32'(off * 16),
                           len: 8'(((sym - off > 16) ? 16 : sym - off) - 1)});
      for (int s = 0; s < sym; s++)
        exp_sym.push_back('{d: mkdata(la + 32'(s * 16)), last: (s == sym - 1),
                            user: (ln == p) && (s == 0)});
    end
  endtask

  task automatic reenable(input int ll, input int nl, input int fp, input int cnt,
                          input logic [31:0] base, input logic [31:0] step);
    @(negedge aclk); enable = 1'b0;
    repeat (2) @(negedge aclk);
    cfg_ll = ll; cfg_nl = nl; cfg_fp = fp; cfg_cnt = cnt; cfg_base = base; cfg_step = step;
    frame  = '{LineLength: 16'(ll), Lines: 16'(nl), FramePhases: 8'(fp)};
    buffer = '{Base: base, LineStep: step, Count: 8'(cnt)};
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    m_phase = 0; m_buf = 0;
  endtask

  task automatic pulse();
    @(negedge aclk); field_start = 1'b1;
    @(negedge aclk); field_start = 1'b0;
  endtask

  task automatic wait_rready(input string tag);
    int n = 0;
    while (!m_axi_rready && n < 200) begin @(negedge aclk); n++; end
    chk({tag, "_rready"}, m_axi_rready, 1'b1);
  endtask

  task automatic wait_phase(input string tag, input int bound);
    int n = 0;
    while (!busy && n < 20) begin @(negedge aclk); n++; end
    chk({tag, "_busy_rise"}, busy, 1'b1);
    n = 0;
    while (busy && n < bound) begin @(negedge aclk); n++; end
    chk({tag, "_busy_fall"}, busy, 1'b0);
    n = 0;
    while (rx.size() < exp_sym.size() && n < bound) begin @(negedge aclk); n++; end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_ar_count"}, ar_log.size(), exp_ar.size());
    for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++) begin
      chk($sformatf("%s_ar%0d_addr", tag, i), ar_log[i].addr, exp_ar[i].addr);
      chk($sformatf("%s_ar%0d_len", tag, i), ar_log[i].len, exp_ar[i].len);
    end
    chk({tag, "_sym_count"}, rx.size(), exp_sym.size());
    for (int i = 0; i < rx.size() && i < exp_sym.size(); i++) begin
      chk($sformatf("%s_s%0d_data", tag, i), rx[i].d, exp_sym[i].d);
      chk($sformatf("%s_s%0d_last", tag, i), rx[i].last, exp_sym[i].last);
      chk($sformatf("%s_s%0d_user", tag, i), rx[i].user, exp_sym[i].user);
    end
  endtask

  task automatic start_phase();
    exp_ar.delete(); exp_sym.delete(); ar_log.delete(); rx.delete();
    model_phase(m_phase, m_buf);
  endtask

  task automatic finish_phase(input string tag);
    wait_phase(tag, 3000);
    compare(tag);
    m_phase++;
    if (m_phase >= cfg_fp) begin m_phase = 0; m_buf = (m_buf + 1) % cfg_cnt; end
    chk({tag, "_phase"}, phase, 8'(m_phase));
    chk({tag, "_buf_idx"}, buf_idx, 8'(m_buf));
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; field_start = 1'b0; frame = '0; buffer = '0;
    #23;
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_phase", phase, 8'd0);
    chk("rst_buf_idx", buf_idx, 8'd0);
    chk("rst_errs", {err_resp, err_ovr, err_cfg}, 3'b000);
    @(negedge aclk); aresetn = 1'b1;

    // Nominal frame, both phases of buffer 0.
    reenable(70, 4, 2, 2, 32'h0001_0000, 32'h0000_1000);
    start_phase(); pulse(); finish_phase("nom");
    if (ar_log.size() == 4) begin
      chk("nom_ar0", {ar_log[0].addr, ar_log[0].len}, {32'h0001_0000, 8'd15});
      chk("nom_ar1", {ar_log[1].addr, ar_log[1].len}, {32'h0001_0100, 8'd1});
      chk("nom_ar2", {ar_log[2].addr, ar_log[2].len}, {32'h0001_2000, 8'd15});
      chk("nom_ar3", {ar_log[3].addr, ar_log[3].len}, {32'h0001_2100, 8'd1});
    end
    if (rx.size() == 36) begin
      chk("nom_tlast18", rx[17].last, 1'b1);
      chk("nom_tlast36", rx[35].last, 1'b1);
      chk("nom_tuser1", rx[0].user, 1'b1);
      chk("nom_tuser2", rx[1].user, 1'b0);
    end
    chk("nom_err_ovr_clear", err_ovr, 1'b0);

    start_phase(); pulse(); finish_phase("ph1");
    if (ar_log.size() >= 3) begin
      chk("ph1_addr_a", ar_log[0].addr, 32'h0001_1000);
      chk("ph1_addr_b", ar_log[2].addr, 32'h0001_3000);
    end

    // Buffer 1, with an overrun pulse during DATA.
    start_phase(); pulse(); wait_rready("ovr"); pulse(); finish_phase("ovr");
    chk("ovr_err_ovr", err_ovr, 1'b1);
    if (ar_log.size() > 0) chk("buf1_addr", ar_log[0].addr, 32'h0001_4000);

    // Response error on one beat; data still delivered.
    chk("resp_err_clear", err_resp, 1'b0);
    start_phase(); inject_err = 1'b1; pulse(); finish_phase("rresp");
    chk("rresp_err_resp", err_resp, 1'b1);

    // Random configurations, a few phases each.
    for (int k = 0; k < 4; k++) begin
      int nl;
      int fp;
      nl = $urandom_range(1, 5);
      fp = $urandom_range(1, (nl < 3) ? nl : 3);
      reenable($urandom_range(1, 140), nl, fp, $urandom_range(1, 3), $urandom,
               32'($urandom_range(0, 32'h3FFFF)));
      for (int j = 0; j < 3; j++) begin
        start_phase(); pulse(); finish_phase($sformatf("rnd%0d_%0d", k, j));
      end
    end

    // Backpressure: 64-symbol FIFO caps fetching at four bursts.
    reenable(256, 2, 1, 1, 32'h0040_0000, 32'h0000_0400);
    start_phase(); bp = 1'b1; pulse();
    repeat (300) @(negedge aclk);
    chk("bp_ar_count", ar_log.size(), 4);
    chk("bp_arvalid", m_axi_arvalid, 1'b0);
    chk("bp_busy", busy, 1'b1);
    chk("bp_tvalid", m_tvalid, 1'b1);
    chk("bp_rx_empty", rx.size(), 0);
    bp = 1'b0;
    finish_phase("bp");

    // Invalid configuration.
    reenable(70, 4, 2, 0, 32'h0001_0000, 32'h0000_1000);
    ar_log.delete(); pulse();
    repeat (30) @(negedge aclk);
    chk("cfg_err_cfg", err_cfg, 1'b1);
    chk("cfg_no_ar", ar_log.size(), 0);
    chk("cfg_busy", busy, 1'b0);

    // Enable dropped in DATA: first burst completes, then idle.
    reenable(70, 4, 2, 2, 32'h0001_0000, 32'h0000_1000);
    start_phase(); pulse(); wait_rready("dis");
    enable = 1'b0;
    begin
      int n = 0;
      while (busy && n < 200) begin @(negedge aclk); n++; end
    end
    repeat (40) @(negedge aclk);
    chk("dis_ar_count", ar_log.size(), 1);
    chk("dis_rx_count", rx.size(), 16);
    for (int i = 0; i < rx.size() && i < exp_sym.size(); i++)
      chk($sformatf("dis_s%0d", i), {rx[i].d, rx[i].last, rx[i].user},
          {exp_sym[i].d, exp_sym[i].last, exp_sym[i].user});
    chk("dis_busy", busy, 1'b0);
    chk("dis_phase", phase, 8'd0);
    chk("dis_arvalid", m_axi_arvalid, 1'b0);

    // Asynchronous reset in the middle of a burst.
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    ar_log.delete(); pulse(); wait_rready("arst");
    #2 aresetn = 1'b0;
    #1;
    chk("arst_ar", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, '0);
    chk("arst_rready", m_axi_rready, 1'b0);
    chk("arst_stream", {m_tvalid, m_tdata, m_tlast, m_tuser}, '0);
    chk("arst_status", {busy, phase, buf_idx}, '0);
    chk("arst_errs", {err_resp, err_ovr, err_cfg}, 3'b000);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
